mdu: RTL
========

Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, in parallel with the single-cycle ALU.
- Fed by the same forwarded operand bus (inA = rs, inB = rt).
- Holds the architectural HI/LO registers.
- Its mfhi/mflo read value joins the ALU result in the EX result mux.
- `busy` drives the hazard unit's stall.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu; must be ≥1.
- DIV_CYCLES, 10, busy duration of div/divu; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  qualifies a write-type op (mdOp 000–101) for one cycle.
- mdOp  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
- inA  in  32  operand A (rs).
- inB  in  32  operand B (rt).
- busy  out  1  multi-cycle op in flight.
- out  out  32  HI/LO read result.

Behaviour:
- Reset (sync, on the edge where reset=1):
  - HI=0, LO=0, busy=0, cycle counter=0.
  - Any in-flight result is discarded; reset overrides start.
- out (combinational):
  - mdOp=110 → HI; mdOp=111 → LO; else 0.
  - Independent of start and busy. During busy, out shows the old HI/LO. The pipeline must stall the read.
- Launch (edge with start=1, busy=0, mdOp in 000–011):
  - Capture operands and op into internal registers.
  - Compute the result into a pending HI/LO pair; HI/LO themselves are not yet written.
  - Load counter = MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu); busy=1 from the next cycle.
- Countdown:
  - Each edge with busy=1 decrements the counter.
  - On the edge where the counter goes 1→0: commit pending→HI/LO and clear busy.
  - Net effect: busy is high for exactly N cycles after the launch edge. A read issued in the first cycle after busy falls sees the new values.
- mthi/mtlo (start=1, busy=0, mdOp 100/101): HI or LO ← inA at that edge; busy stays 0; the other register is unchanged.
- start=1 with mdOp 110/111: no state change.
- start=1 while busy=1: ignored entirely. No restart, and operands, counter and HI/LO are all unaffected. The hazard unit guarantees this case does not occur; the RTL must still tolerate it.
- Arithmetic:
  - mult: signed 32×32→64. HI = product[63:32], LO = product[31:0].
  - multu: same split, unsigned.
  - div: signed. LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - divu: unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (div or divu): HI/LO unchanged at commit; busy still lasts DIV_CYCLES.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: a div/divu launched with inB==0 sets busy for exactly 1 cycle; HI/LO stay unchanged. All other ops keep their full latency.
- Undefined: divide by zero takes the full DIV_CYCLES, as specified above.

Test Plan:
- reset 1 cycle, then mdOp=110 and mdOp=111 → out=0x00000000 both; busy=0.
- mult, inA=0xFFFFFFFF, inB=0x00000002, start 1 cycle:
  - busy high exactly 5 cycles.
  - After busy falls: mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFFE.
  - Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div, inA=0xFFFFFFF9 (−7), inB=0x00000002:
  - busy 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 → LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi inA=0x12345678 then mtlo inA=0x9ABCDEF0, on consecutive cycles:
  - No busy.
  - Next cycle mfhi=0x12345678, mflo=0x9ABCDEF0.
  - Then div by zero: HI/LO unchanged; busy 10 cycles, or 1 with MDU_ZERO_SKIP_EN.
- Start-while-busy and reset mid-op:
  - Launch mult 3×4; on busy cycle 2, assert start with div 100/7 → ignored; result HI=0, LO=12 after 5 cycles.
  - Relaunch; assert reset on busy cycle 3 → busy=0 and HI=LO=0 next cycle; no commit afterwards.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; results commit after a fixed busy latency.
// Optional `MDU_ZERO_SKIP_EN: a divide by zero finishes after a single busy cycle.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        busy,
  output logic [31:0] out
);

  // state  | meaning
  // S_IDLE | accepts mult/div launches and mthi/mtlo writes
  // S_BUSY | counting down; pending result commits when the count reaches 0
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic [63:0] prod_s, prod_u, prod;
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] dvd, dvs, dvs_nz, q_raw, r_raw, quo, rem;

  always_comb begin
    prod_s = $signed({{32{inA[31]}}, inA}) * $signed({{32{inB[31]}}, inB});
    prod_u = {32'd0, inA} * {32'd0, inB};
    prod   = mdOp[0] ? prod_u : prod_s;

    // Divide on magnitudes, then restore signs; this also yields the 0x80000000/-1 result.
    div_sgn = ~mdOp[0];
    a_neg   = div_sgn & inA[31];
    b_neg   = div_sgn & inB[31];
    dvd     = a_neg ? -inA : inA;
    dvs     = b_neg ? -inB : inB;
    dvs_nz  = (dvs == 32'd0) ? 32'd1 : dvs;
    q_raw   = dvd / dvs_nz;
    r_raw   = dvd % dvs_nz;
    quo     = (a_neg ^ b_neg) ? -q_raw : q_raw;
    rem     = a_neg ? -r_raw : r_raw;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdOp)
            3'b000, 3'b001: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            3'b010, 3'b011: begin
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_wr_d = (inB != 32'd0);
`ifdef MDU_ZERO_SKIP_EN
              cnt_d     = (inB == 32'd0) ? CW'(1) : CW'(DIV_CYCLES);
`else
              cnt_d     = CW'(DIV_CYCLES);
`endif
              state_d   = S_BUSY;
            end
            3'b100:  hi_d = inA;
            3'b101:  lo_d = inA;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign out  = (mdOp == 3'b110) ? hi_q : (mdOp == 3'b111) ? lo_q : 32'd0;

endmodule
